nrzi_byte_receiver: RTL and testbench

Serial receive end for the team's single-wire NRZI link: samples the line once per clock, recovers bits by comparing each sample with the previous one (XNOR: no transition = 1, transition = 0), frames them and delivers parallel bytes to the consumer through a valid/ack handshake. It is the counterpart of the link transmitter, which toggles the line for every 0 bit. It sits between the pad-side line input and the consumer logic.

---
 rtl/nrzi_byte_receiver_if.sv | 33 +++
 rtl/nrzi_byte_receiver.sv | 126 ++++++++++++
 tb/tb_nrzi_byte_receiver.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/nrzi_byte_receiver_if.sv
// Bundle of line, parallel-byte handshake and status signals for the NRZI byte receiver.
// The master side is the receiver and the slave side is the line source plus consumer.
interface nrzi_byte_receiver_if #(
    parameter int W = 8
);
    logic         rxd;
    logic [W-1:0] data_out;
    logic         valid;
    logic         ack;
    logic         busy;
    logic         overrun;
    logic         frame_err;

    modport master (
        input  rxd,
        input  ack,
        output data_out,
        output valid,
        output busy,
        output overrun,
        output frame_err
    );

    modport slave (
        output rxd,
        output ack,
        input  data_out,
        input  valid,
        input  busy,
        input  overrun,
        input  frame_err
    );
endinterface

// File: rtl/nrzi_byte_receiver.sv
// NRZI serial receiver: decodes line transitions into bits, frames start/W data/stop,
// and hands bytes to the consumer through a valid/ack buffer with sticky overrun.
module nrzi_byte_receiver #(
    parameter int W = 8
) (
    input  logic              clock,
    input  logic              reset,
    nrzi_byte_receiver_if.master bus
);
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    // A sample equal to the previous one decodes as 1, a transition as 0.
    function automatic logic nrzi_decode(input logic cur, input logic prev);
        return ~(cur ^ prev);
    endfunction

    state_t         state_r,     state_next_s;
    logic           prev_r;
    logic [CNT_W-1:0] cnt_r,     cnt_next_s;
    logic [W-1:0]   shift_r,     shift_next_s;
    logic [W-1:0]   data_r,      data_next_s;
    logic           valid_r,     valid_next_s;
    logic           overrun_r,   overrun_next_s;
    logic           frame_err_r, frame_err_next_s;
    logic           busy_r,      busy_next_s;
    logic           bit_s;
    logic           deliver_s;

    // Frame sequencing, delivery buffer and status flags for the current edge.
    always_comb begin
        state_next_s     = state_r;
        cnt_next_s       = cnt_r;
        shift_next_s     = shift_r;
        data_next_s      = data_r;
        valid_next_s     = valid_r;
        overrun_next_s   = overrun_r;
        frame_err_next_s = 1'b0;
        deliver_s        = 1'b0;
        bit_s            = nrzi_decode(bus.rxd, prev_r);

        case (state_r)
            IDLE: begin
                if (bit_s == 1'b0) begin
                    state_next_s = DATA;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else begin
                    state_next_s = IDLE;
                end
            end
            DATA: begin
                shift_next_s = {bit_s, shift_r[W-1:1]};
                cnt_next_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == CNT_W'(W - 1)) begin
                    state_next_s = STOP;
                end else begin
                    state_next_s = DATA;
                end
            end
            STOP: begin
                state_next_s = IDLE;
                if (bit_s == 1'b1) begin
                    deliver_s = 1'b1;
                end else begin
                    frame_err_next_s = 1'b1;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase

        // A pending byte may be replaced only when the consumer takes it on this same edge.
        if (deliver_s) begin
            if (!valid_r || bus.ack) begin
                data_next_s  = shift_r;
                valid_next_s = 1'b1;
            end else begin
                overrun_next_s = 1'b1;
            end
        end else if (valid_r && bus.ack) begin
            valid_next_s = 1'b0;
        end else begin
            valid_next_s = valid_r;
        end

        busy_next_s = (state_next_s != IDLE);
    end

    // State, line history and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            prev_r      <= 1'b1;
            cnt_r       <= {CNT_W{1'b0}};
            shift_r     <= {W{1'b0}};
            data_r      <= {W{1'b0}};
            valid_r     <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            prev_r      <= bus.rxd;
            cnt_r       <= cnt_next_s;
            shift_r     <= shift_next_s;
            data_r      <= data_next_s;
            valid_r     <= valid_next_s;
            overrun_r   <= overrun_next_s;
            frame_err_r <= frame_err_next_s;
            busy_r      <= busy_next_s;
        end
    end

    assign bus.data_out  = data_r;
    assign bus.valid     = valid_r;
    assign bus.busy      = busy_r;
    assign bus.overrun   = overrun_r;
    assign bus.frame_err = frame_err_r;
endmodule

// File: tb/tb_nrzi_byte_receiver.sv
// Directed bench for nrzi_byte_receiver: NRZI-encodes frames on the line and checks
// delivery, handshake, overrun, framing error and mid-frame reset behaviour.
module tb_nrzi_byte_receiver;
    logic clock;
    logic reset;
    logic line;
    int   checks;
    int   failures;

    nrzi_byte_receiver_if #(.W(8)) bus ();

    nrzi_byte_receiver #(.W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Encode one decoded bit: a 0 toggles the line, a 1 holds it.
    task automatic drive_bit(input logic d);
        if (d == 1'b0) line = ~line;
        bus.rxd = line;
        tick();
    endtask

    task automatic send_start();
        drive_bit(1'b0);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_start: got %b expected 1", bus.busy);
        end
    endtask

    task automatic send_data(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            drive_bit(b[i]);
            checks++;
            if (bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL busy_data_bit%0d: got %b expected 1", i, bus.busy);
            end
        end
    endtask

    task automatic send_stop(input logic good, input logic ack_v);
        bus.ack = ack_v;
        drive_bit(good);
        bus.ack = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_stop: got %b expected 0", bus.busy);
        end
    endtask

    task automatic pulse_ack();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        line = 1'b1;
        bus.rxd = 1'b1;
        bus.ack = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({bus.valid, bus.busy, bus.overrun, bus.frame_err, bus.data_out} !== 12'h000) begin
            failures++;
            $display("FAIL reset_state: got v=%b b=%b o=%b fe=%b d=%h expected all 0",
                     bus.valid, bus.busy, bus.overrun, bus.frame_err, bus.data_out);
        end
    endtask

    task automatic test_single();
        send_start();
        send_data(8'hA5);
        send_stop(1'b1, 1'b0);
        checks++;
        if (bus.valid !== 1'b1 || bus.data_out !== 8'hA5) begin
            failures++;
            $display("FAIL single_deliver: got v=%b d=%h expected v=1 d=a5", bus.valid, bus.data_out);
        end
        tick();
        checks++;
        if (bus.valid !== 1'b1) begin
            failures++;
            $display("FAIL single_hold: got v=%b expected 1", bus.valid);
        end
        pulse_ack();
        checks++;
        if (bus.valid !== 1'b0 || bus.data_out !== 8'hA5) begin
            failures++;
            $display("FAIL single_ack: got v=%b d=%h expected v=0 d=a5", bus.valid, bus.data_out);
        end
    endtask

    task automatic test_back_to_back();
        send_start();
        send_data(8'hA5);
        send_stop(1'b1, 1'b0);
        send_start();
        send_data(8'h3C);
        send_stop(1'b1, 1'b1);
        checks++;
        if (bus.valid !== 1'b1 || bus.data_out !== 8'h3C || bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back: got v=%b d=%h o=%b expected v=1 d=3c o=0",
                     bus.valid, bus.data_out, bus.overrun);
        end
        pulse_ack();
        checks++;
        if (bus.valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ack: got v=%b expected 0", bus.valid);
        end
    endtask

    task automatic test_overrun();
        send_start();
        send_data(8'h11);
        send_stop(1'b1, 1'b0);
        send_start();
        send_data(8'h22);
        send_stop(1'b1, 1'b0);
        checks++;
        if (bus.valid !== 1'b1 || bus.data_out !== 8'h11 || bus.overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set: got v=%b d=%h o=%b expected v=1 d=11 o=1",
                     bus.valid, bus.data_out, bus.overrun);
        end
        pulse_ack();
        tick();
        pulse_ack();
        checks++;
        if (bus.valid !== 1'b0 || bus.overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky: got v=%b o=%b expected v=0 o=1", bus.valid, bus.overrun);
        end
    endtask

    task automatic test_frame_err();
        send_start();
        send_data(8'h77);
        send_stop(1'b0, 1'b0);
        checks++;
        if (bus.frame_err !== 1'b1 || bus.valid !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_pulse: got fe=%b v=%b expected fe=1 v=0", bus.frame_err, bus.valid);
        end
        tick();
        checks++;
        if (bus.frame_err !== 1'b0 || bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_clear: got fe=%b b=%b v=%b expected 0 0 0",
                     bus.frame_err, bus.busy, bus.valid);
        end
        send_start();
        send_data(8'h5A);
        send_stop(1'b1, 1'b0);
        checks++;
        if (bus.valid !== 1'b1 || bus.data_out !== 8'h5A || bus.frame_err !== 1'b0) begin
            failures++;
            $display("FAIL after_frame_err: got v=%b d=%h fe=%b expected v=1 d=5a fe=0",
                     bus.valid, bus.data_out, bus.frame_err);
        end
        pulse_ack();
    endtask

    task automatic test_reset_mid();
        send_start();
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        reset = 1'b1;
        line = 1'b0;
        bus.rxd = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.valid, bus.busy, bus.overrun, bus.frame_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_mid_state: got v=%b b=%b o=%b fe=%b expected all 0",
                     bus.valid, bus.busy, bus.overrun, bus.frame_err);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b1 || bus.frame_err !== 1'b0 || bus.valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_start: got b=%b fe=%b v=%b expected b=1 fe=0 v=0",
                     bus.busy, bus.frame_err, bus.valid);
        end
        send_data(8'hC3);
        send_stop(1'b1, 1'b0);
        checks++;
        if (bus.valid !== 1'b1 || bus.data_out !== 8'hC3 || bus.overrun !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_frame: got v=%b d=%h o=%b expected v=1 d=c3 o=0",
                     bus.valid, bus.data_out, bus.overrun);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
